// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, the fetch bundle layout and
// the pipe_skid_buf state encodings.
package cpu_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned PC_W_DEF   = 32;
   localparam int unsigned LANES_DEF  = 2;

   // Occupancy states of the 2-entry skid buffer
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_FULL    = 2'd1;
   localparam logic [1:0] ST_SKIDDED = 2'd2;

   typedef struct packed {
      logic [LANES_DEF-1:0][DATA_W_DEF-1:0] inst;
      logic [PC_W_DEF-1:0]                  pc;
      logic [LANES_DEF-1:0]                 mask;
   } bundle_t;

   function automatic int unsigned bundle_w(input int unsigned lanes,
                                            input int unsigned data_w,
                                            input int unsigned pc_w);
      return lanes * data_w + pc_w + lanes;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline stage with flush: a 2-entry skid buffer with
// registered in_ready (SKID=1), or a single entry with combinational in_ready.
module pipe_skid_buf
   import cpu_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned SKID = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   generate
      if (SKID != 0) begin : g_skid
         logic [1:0]   state;
         logic [1:0]   state_nxt;
         logic [W-1:0] main_q;
         logic [W-1:0] skid_q;
         logic         ready_q;
         logic         accept;
         logic         drain;

         assign accept = in_valid && ready_q;
         assign drain  = (state != ST_EMPTY) && out_ready;

         always_comb begin
            state_nxt = state;
            case (state)
               ST_EMPTY:   if (accept) state_nxt = ST_FULL;
               ST_FULL: begin
                  if (accept && !drain)      state_nxt = ST_SKIDDED;
                  else if (!accept && drain) state_nxt = ST_EMPTY;
               end
               ST_SKIDDED: if (drain) state_nxt = ST_FULL;
               default:    state_nxt = ST_EMPTY;
            endcase
         end

         // Flush clears only occupancy; payload registers keep stale contents
         always_ff @(posedge clk) begin
            if (rst) begin
               state   <= ST_EMPTY;
               ready_q <= 1'b1;
               main_q  <= '0;
               skid_q  <= '0;
            end else if (flush) begin
               state   <= ST_EMPTY;
               ready_q <= 1'b1;
            end else begin
               state   <= state_nxt;
               ready_q <= (state_nxt != ST_SKIDDED);
               if (state == ST_SKIDDED) begin
                  if (drain) main_q <= skid_q;
               end else if (accept) begin
                  if (state == ST_EMPTY || drain) main_q <= in_data;
                  else                            skid_q <= in_data;
               end
            end
         end

         assign in_ready  = ready_q;
         assign out_valid = (state != ST_EMPTY);
         assign out_data  = main_q;
      end else begin : g_single
         logic         valid_q;
         logic [W-1:0] data_q;

         assign in_ready = !valid_q || out_ready;

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else if (flush) begin
               valid_q <= 1'b0;
            end else if (in_valid && in_ready) begin
               valid_q <= 1'b1;
               data_q  <= in_data;
            end else if (out_ready) begin
               valid_q <= 1'b0;
            end
         end

         assign out_valid = valid_q;
         assign out_data  = data_q;
      end
   endgenerate

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: fetch bundle (LANES words, PC, lane mask) through a
// flushable valid/ready stage, plus a saturating back-pressure counter.
module if_id_pipe_reg
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned LANES  = LANES_DEF,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_inst,
   input  logic [PC_W-1:0]         in_pc,
   input  logic [LANES-1:0]        in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_inst,
   output logic [PC_W-1:0]         out_pc,
   output logic [LANES-1:0]        out_mask,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int unsigned PAY_W = bundle_w(LANES, DATA_W, PC_W);

   logic [PAY_W-1:0] in_data;
   logic [PAY_W-1:0] out_data;

   assign in_data = {in_inst, in_pc, in_mask};
   assign {out_inst, out_pc, out_mask} = out_data;

   pipe_skid_buf #(
      .W    (PAY_W),
      .SKID (SKID)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a SKID=1/LANES=2 instance and a SKID=0/LANES=1/CNT_W=4
// instance, both checked every cycle against queue-based reference models.
module tb_if_id_pipe_reg;

   localparam int DW = 32;
   localparam int PW = 32;
   localparam int LA = 2;

   typedef struct packed {
      logic [63:0] inst;
      logic [31:0] pc;
      logic [1:0]  mask;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic              a_flush, a_iv, a_ir, a_ov, a_or;
   logic [LA*DW-1:0]  a_ii, a_oi;
   logic [PW-1:0]     a_ipc, a_opc;
   logic [LA-1:0]     a_im, a_om;
   logic [15:0]       a_cnt;

   logic              b_flush, b_iv, b_ir, b_ov, b_or;
   logic [DW-1:0]     b_ii, b_oi;
   logic [PW-1:0]     b_ipc, b_opc;
   logic [0:0]        b_im, b_om;
   logic [3:0]        b_cnt;

   if_id_pipe_reg #(.DATA_W(DW), .PC_W(PW), .LANES(LA), .SKID(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
      .in_inst(a_ii), .in_pc(a_ipc), .in_mask(a_im), .out_valid(a_ov), .out_ready(a_or),
      .out_inst(a_oi), .out_pc(a_opc), .out_mask(a_om), .stall_cnt(a_cnt));

   if_id_pipe_reg #(.DATA_W(DW), .PC_W(PW), .LANES(1), .SKID(0), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
      .in_inst(b_ii), .in_pc(b_ipc), .in_mask(b_im), .out_valid(b_ov), .out_ready(b_or),
      .out_inst(b_oi), .out_pc(b_opc), .out_mask(b_om), .stall_cnt(b_cnt));

   // Reference models: FIFO of held bundles, capacity 2 (A) or 1 (B)
   ent_t        qa[$];
   ent_t        qb[$];
   int unsigned ca, cb;
   bit          a_hold, b_hold;
   int          n_tests, n_fail;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit   acc_a, acc_b;
      ent_t ea, eb;
      acc_a = a_iv && (qa.size() < 2);
      acc_b = b_iv && (qb.size() == 0 || b_or);
      ea.inst = a_ii; ea.pc = a_ipc; ea.mask = a_im;
      eb.inst = {32'b0, b_ii}; eb.pc = b_ipc; eb.mask = {1'b0, b_im};
      if (rst) begin
         qa.delete(); qb.delete(); ca = 0; cb = 0;
         a_hold = 1'b0; b_hold = 1'b0;
      end else begin
         if (qa.size() > 0 && !a_or && ca < 65535) ca++;
         if (qb.size() > 0 && !b_or && cb < 15) cb++;
         a_hold = a_iv && !acc_a && !a_flush;
         b_hold = b_iv && !acc_b && !b_flush;
         if (a_flush) qa.delete();
         else begin
            if (qa.size() > 0 && a_or) void'(qa.pop_front());
            if (acc_a) qa.push_back(ea);
         end
         if (b_flush) qb.delete();
         else begin
            if (qb.size() > 0 && b_or) void'(qb.pop_front());
            if (acc_b) qb.push_back(eb);
         end
      end
   endtask

   task automatic compare();
      chk("a_valid", a_ov, qa.size() > 0);
      if (qa.size() > 0) begin
         chk("a_inst", a_oi, qa[0].inst);
         chk("a_pc", a_opc, qa[0].pc);
         chk("a_mask", a_om, qa[0].mask);
      end
      chk("a_ready", a_ir, qa.size() < 2);
      chk("a_stall", a_cnt, ca);
      chk("b_valid", b_ov, qb.size() > 0);
      if (qb.size() > 0) begin
         chk("b_inst", b_oi, qb[0].inst[31:0]);
         chk("b_pc", b_opc, qb[0].pc);
         chk("b_mask", b_om, qb[0].mask[0]);
      end
      chk("b_ready", b_ir, (qb.size() == 0) || b_or);
      chk("b_stall", b_cnt, cb);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic put_a(input bit v, input logic [31:0] pc);
      a_iv = v; a_ipc = pc; a_ii = {$urandom, $urandom}; a_im = 2'($urandom_range(0, 3));
   endtask

   task automatic put_b(input bit v, input logic [31:0] pc);
      b_iv = v; b_ipc = pc; b_ii = $urandom; b_im = 1'b1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; ca = 0; cb = 0; a_hold = 1'b0; b_hold = 1'b0;
      rst = 1'b1; a_flush = 1'b0; b_flush = 1'b0; a_or = 1'b1; b_or = 1'b1;
      put_a(1'b1, 32'h0000_0040);
      put_b(1'b1, 32'h0000_0080);

      // Reset with in_valid high
      step(); step();
      chk("rst_a_valid", a_ov, 1'b0);
      chk("rst_a_inst", a_oi, 64'h0);
      chk("rst_a_stall", a_cnt, 16'h0);
      chk("rst_a_ready", a_ir, 1'b1);
      chk("rst_b_valid", b_ov, 1'b0);
      rst = 1'b0; put_a(1'b0, 32'h0); put_b(1'b0, 32'h0);
      step();
      chk("post_rst_a_ready", a_ir, 1'b1);

      // Streaming
      for (int k = 0; k < 3; k++) begin
         put_a(1'b1, 32'h100 + 32'(8 * k));
         step();
         chk("stream_pc", a_opc, 32'h100 + 32'(8 * k));
         chk("stream_valid", a_ov, 1'b1);
         chk("stream_ready", a_ir, 1'b1);
      end
      put_a(1'b0, 32'h0);
      step();

      // Back-pressure into the skid entry
      a_or = 1'b0;
      put_a(1'b1, 32'h200); step();
      chk("bp_pc0", a_opc, 32'h200);
      put_a(1'b1, 32'h208); step();
      chk("bp_ready_low", a_ir, 1'b0);
      put_a(1'b0, 32'h0); step();
      chk("bp_hold_pc", a_opc, 32'h200);
      chk("bp_stall2", a_cnt, 16'd2);
      a_or = 1'b1; step();
      chk("bp_pc1", a_opc, 32'h208);
      chk("bp_ready_back", a_ir, 1'b1);
      step();
      chk("bp_drained", a_ov, 1'b0);
      chk("bp_stall_kept", a_cnt, 16'd2);

      // Flush while skidded, with a bundle offered
      a_or = 1'b0;
      put_a(1'b1, 32'h2F0); step();
      put_a(1'b1, 32'h2F8); step();
      chk("fl_skidded", a_ir, 1'b0);
      put_a(1'b1, 32'h300); a_flush = 1'b1; step();
      chk("fl_valid", a_ov, 1'b0);
      chk("fl_ready", a_ir, 1'b1);
      a_flush = 1'b0; put_a(1'b0, 32'h0); a_or = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("fl_no_300", a_ov, 1'b0);
      end

      // SKID=0: out_ready toggles every cycle
      for (int k = 0; k < 20; k++) begin
         b_or = k[0];
         if (!b_hold) put_b(1'b1, 32'h400 + 32'(4 * k));
         step();
         chk("tog_ready_rel", b_ir, !b_ov || b_or);
      end
      b_or = 1'b1; step();
      put_b(1'b0, 32'h0); step();

      // Saturation of the 4-bit stall counter
      b_or = 1'b0;
      put_b(1'b1, 32'h500); step();
      put_b(1'b0, 32'h0);
      for (int k = 0; k < 20; k++) step();
      chk("sat_cnt", b_cnt, 4'd15);
      chk("sat_pc", b_opc, 32'h500);
      b_or = 1'b1; step();

      // Randomised traffic on both instances, including flush and reset
      for (int k = 0; k < 600; k++) begin
         rst     = ($urandom_range(0, 149) == 0);
         a_flush = ($urandom_range(0, 15) == 0);
         b_flush = ($urandom_range(0, 15) == 0);
         a_or    = ($urandom_range(0, 3) != 0);
         b_or    = ($urandom_range(0, 2) != 0);
         if (!a_hold) put_a($urandom_range(0, 3) != 0, $urandom);
         if (!b_hold) begin
            put_b($urandom_range(0, 3) != 0, $urandom);
            b_im = 1'($urandom_range(0, 1));
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF→ID pipeline register carrying LANES instruction words plus PC and per-lane valid mask, with a valid/ready handshake, an optional 2-entry skid buffer, flush, and a stall counter. It replaces the fixed 32-bit unconditional register between fetch and decode. It lets decode back-pressure fetch without losing instructions, and lets branch resolution squash in-flight fetch data.

Parameters:
DATA_W, 32, width of one instruction word
PC_W, 32, width of the fetch PC
LANES, 2, instructions per fetch bundle (≥1)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  squash all held and incoming bundles
in_valid  in  1  fetch presents a bundle
in_ready  out  1  stage can accept a bundle this cycle
in_inst  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
in_pc  in  PC_W  PC of lane 0
in_mask  in  LANES  per-lane valid bits
out_valid  out  1  bundle presented to decode
out_ready  in  1  decode accepts the bundle
out_inst  out  LANES*DATA_W  held bundle
out_pc  out  PC_W  held PC
out_mask  out  LANES  held lane mask
stall_cnt  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Clock is clk; reset is synchronous, active-high (rst), sampled on the rising edge of clk.
- Reset values: out_valid=0, out_inst=0, out_pc=0, out_mask=0, stall_cnt=0. Skid entry is empty and zeroed. With SKID=1, in_ready=1 from the first cycle after reset.
- Handshake: a transfer occurs on an edge where valid && ready on that side. out_* hold stable while out_valid && !out_ready. Producers must not drop in_valid before in_ready.
- Latency: an accepted bundle appears on out_* exactly 1 cycle later if the main entry is empty or is draining that cycle.
- SKID=1 states:
  - EMPTY (main invalid): accept → FULL.
  - FULL: accept && drain → FULL with new data; drain only → EMPTY; accept without drain → SKIDDED (new bundle goes to the skid entry); neither → FULL.
  - SKIDDED: in_ready=0; drain → FULL, skid entry moves to main.
  - in_ready is registered and equals !(next state == SKIDDED).
  - The SKID=1 configuration sustains 1 bundle/cycle with no combinational path from out_ready to in_ready.
- SKID=0: single entry. in_ready = !out_valid || out_ready (combinational); the skid entry is not built.
- Flush: takes priority over everything except rst. On the next edge, out_valid=0, the skid entry is empty, and in_ready=1. A bundle offered in the flush cycle is dropped, with in_ready still asserted that cycle. Data registers keep stale values; only valid bits clear.
- out_mask: captured verbatim. A bundle with mask 0 is still a legal transfer.
- stall_cnt: +1 each cycle with out_valid && !out_ready; saturates at 2^CNT_W−1; cleared only by rst.
- rst mid-transfer: both entries are discarded; behaviour is identical to power-on reset.

Decomposition:
- Shared package (cpu_pkg): DATA_W and PC_W defaults, and a bundle typedef {inst[LANES], pc, mask}.
- One natural sub-module, pipe_skid_buf: a generic payload-width skid buffer with valid/ready/flush. if_id_pipe_reg instantiates it with payload = LANES*DATA_W+PC_W+LANES and adds stall_cnt.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, out_inst=0, stall_cnt=0, in_ready=1 after release.
- Streaming: out_ready=1, feed bundles PC=0x100,0x108,0x110 on consecutive cycles → each appears 1 cycle later in order, with no bubble and in_ready constantly 1.
- Back-pressure: out_ready=0 while sending PC=0x200 then 0x208 → out holds 0x200, 0x208 stored in skid, in_ready=0. Release out_ready → 0x200 then 0x208 in order, and stall_cnt equals the number of held cycles.
- Flush in SKIDDED with in_valid=1 (PC=0x300) → next cycle out_valid=0, in_ready=1, 0x300 never appears.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles → stall_cnt stops at 15.
- SKID=0, LANES=1: out_ready toggles every cycle → in_ready equals !out_valid || out_ready each cycle, data order preserved, mask 1'b1 passed through.
